// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU execution resources.
// ALU selects, opcodes and the Fibonacci demo ROM image.
package cpu_pkg;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_NAND = 3'b110;
  localparam logic [2:0] ALU_LSL  = 3'b111;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_NAND = 4'h8;
  localparam logic [3:0] OP_HALT = 4'h9;
  localparam logic [3:0] OP_LSL  = 4'hA;
  localparam logic [3:0] OP_RSVD = 4'hB;
  localparam logic [3:0] OP_SKIP = 4'hC;
  localparam logic [3:0] OP_BRB  = 4'hD;
  localparam logic [3:0] OP_STUR = 4'hE;
  localparam logic [3:0] OP_LDUR = 4'hF;

  // Index 0 is the leftmost word: program order reads top to bottom.
  localparam logic [0:DEPTH-1][DW-1:0] ROM_IMAGE = {
    16'h1211,
    16'h1306,
    16'h0412,
    16'h0120,
    16'h0240,
    16'h3331,
    16'hC230,
    16'hD500,
    16'h9000,
    16'h9000,
    16'h9000,
    16'h9000,
    16'h9000,
    16'h9000,
    16'h9000,
    16'h9000
  };

  function automatic logic [DW-1:0] rom_word(
    input logic [AW-1:0] addr
  );
    return ROM_IMAGE[addr];
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU.
// Carry is only meaningful for ADD (carry) and SUB (borrow).
module alu16
  import cpu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    sel,
  input  logic [3:0]    shamt,
  output logic [DW-1:0] y,
  output logic          carry
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  // Widened add/sub so bit 16 is the carry or borrow.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
  end

  // Operation select; carry stays low outside ADD/SUB.
  always_comb begin
    y     = '0;
    carry = 1'b0;
    unique case (sel)
      ALU_ADD: begin
        y     = sum[DW-1:0];
        carry = sum[DW];
      end
      ALU_SUB: begin
        y     = diff[DW-1:0];
        carry = diff[DW];
      end
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_NAND: y = ~(a & b);
      ALU_LSL:  y = a << shamt;
      default: begin
        y     = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imem_ram_alu.sv
// Execution resources: ALU, 16x16 data RAM, 16x16 program ROM.
// RAM clears asynchronously on reset; ALU and ROM ignore reset.
module imem_ram_alu
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] alu_b,
  input  logic [2:0]    alu_sel,
  input  logic [3:0]    shamt,
  output logic [DW-1:0] alu_out,
  output logic          carry_out,
  input  logic          ram_we,
  input  logic          ram_oe,
  input  logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_wdata,
  output logic [DW-1:0] ram_rdata,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] instr
);

  logic [DW-1:0] mem [DEPTH];

  alu16 u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .sel   (alu_sel),
    .shamt (shamt),
    .y     (alu_out),
    .carry (carry_out)
  );

  // Data RAM: async clear, otherwise one write per rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // Read port is combinational and gated by output enable.
  always_comb begin
    ram_rdata = '0;
    if (ram_oe) begin
      ram_rdata = mem[ram_addr];
    end
  end

  // Instruction fetch straight from the constant program image.
  always_comb begin
    instr = rom_word(pc);
  end

endmodule

// File: tb/tb_imem_ram_alu.sv
// Self-checking bench for imem_ram_alu.
// Directed cases plus random ALU/RAM traffic against a reference model.
module tb_imem_ram_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [3:0]  shamt;
  logic [15:0] alu_out;
  logic        carry_out;
  logic        ram_we, ram_oe;
  logic [3:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [3:0]  pc;
  logic [15:0] instr;

  int n_checks = 0;
  int n_errors = 0;

  int model_mem [16];
  int rom_exp [16] = '{
    'h1211, 'h1306, 'h0412, 'h0120,
    'h0240, 'h3331, 'hC230, 'hD500,
    'h9000, 'h9000, 'h9000, 'h9000,
    'h9000, 'h9000, 'h9000, 'h9000
  };

  imem_ram_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .shamt     (shamt),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .pc        (pc),
    .instr     (instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU built from arithmetic on plain integers.
  task automatic ref_alu(input int a, input int b, input int sel,
                         input int sh, output int y, output int c);
    int s;
    c = 0;
    case (sel)
      0: begin s = a + b; y = s % 65536; c = (s > 65535) ? 1 : 0; end
      1: begin y = (a - b + 65536) % 65536; c = (a < b) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = 65535 - (a | b);
      6: y = 65535 - (a & b);
      default: y = (a * (1 << sh)) % 65536;
    endcase
  endtask

  task automatic alu_case(input string tag, input int a, input int b,
                          input int sel, input int sh);
    int y, c;
    alu_a = a[15:0];
    alu_b = b[15:0];
    alu_sel = sel[2:0];
    shamt = sh[3:0];
    #1;
    ref_alu(a, b, sel, sh, y, c);
    chk({tag, "_out"}, int'(alu_out), y);
    chk({tag, "_c"}, int'(carry_out), c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_write(input int addr, input int data);
    @(negedge clk);
    ram_we = 1'b1;
    ram_addr = addr[3:0];
    ram_wdata = data[15:0];
    tick();
    model_mem[addr] = data;
    ram_we = 1'b0;
  endtask

  task automatic ram_read(input string tag, input int addr, input bit oe);
    ram_addr = addr[3:0];
    ram_oe = oe;
    #1;
    chk(tag, int'(ram_rdata), oe ? model_mem[addr] : 0);
  endtask

  // Fibonacci program run by a small behavioural control path.
  task automatic run_fib();
    int regs [16];
    int p, steps, op, rd, rn, rm, k;
    int fib_exp [6] = '{1, 2, 3, 5, 8, 13};
    bit halted;
    foreach (regs[i]) regs[i] = 0;
    p = 0;
    k = 0;
    halted = 1'b0;
    for (steps = 0; steps < 200 && !halted; steps++) begin
      pc = p[3:0];
      #1;
      op = int'(instr[15:12]);
      rd = int'(instr[11:8]);
      rn = int'(instr[7:4]);
      rm = int'(instr[3:0]);
      case (op)
        'h0, 'h1, 'h2, 'h3: begin
          alu_a = regs[rn][15:0];
          alu_b = (op == 'h1 || op == 'h3) ? 16'(rm) : regs[rm][15:0];
          alu_sel = (op >= 2) ? 3'b001 : 3'b000;
          shamt = 4'h0;
          #1;
          regs[rd] = int'(alu_out);
          if (rd == 4 && k < 6) begin
            chk($sformatf("fib_r4_%0d", k), regs[4], fib_exp[k]);
            k++;
          end
          p = p + 1;
        end
        'hC: p = (regs[rn] == 0) ? p + 2 : p + 1;
        'hD: p = p - rd;
        'h9: halted = 1'b1;
        default: p = p + 1;
      endcase
    end
    chk("fib_halted", int'(halted), 1);
    chk("fib_count", k, 6);
    chk("fib_halt_pc", p, 8);
  endtask

  initial begin
    int a, b, s, sh, addr, data;
    rst_n = 1'b0;
    alu_a = '0; alu_b = '0; alu_sel = '0; shamt = '0;
    ram_we = 1'b0; ram_oe = 1'b1; ram_addr = '0; ram_wdata = '0;
    pc = '0;
    foreach (model_mem[i]) model_mem[i] = 0;
    #12;
    chk("reset_rdata", int'(ram_rdata), 0);
    rst_n = 1'b1;
    tick();

    alu_case("add_wrap", 'hFFFF, 'h0001, 0, 0);
    alu_case("sub_borrow", 'h0003, 'h0005, 1, 0);
    alu_case("nand", 'hF0F0, 'hFF00, 6, 0);
    alu_case("lsl15", 'h0001, 'h1234, 7, 15);
    alu_case("sub_eq", 'h1234, 'h1234, 1, 0);
    alu_case("nor", 'h0F0F, 'h00FF, 5, 0);
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      s = int'($urandom_range(0, 7));
      sh = int'($urandom_range(0, 15));
      alu_case($sformatf("alu_rnd%0d_op%0d", i, s), a, b, s, sh);
    end

    ram_read("ram_unwritten0", 0, 1'b1);
    ram_write(5, 'h1234);
    ram_write(15, 'hABCD);
    ram_read("ram_a5", 5, 1'b1);
    ram_read("ram_a15", 15, 1'b1);
    ram_read("ram_a0", 0, 1'b1);
    ram_read("ram_oe0", 5, 1'b0);
    ram_oe = 1'b1;

    ram_write(3, 'h5555);
    ram_read("ram_a3_pre", 3, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    foreach (model_mem[i]) model_mem[i] = 0;
    ram_read("rst_a3_now", 3, 1'b1);
    ram_read("rst_a5_now", 5, 1'b1);
    ram_we = 1'b1;
    ram_addr = 4'd9;
    ram_wdata = 16'hBEEF;
    tick();
    ram_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ram_read("rst_write_lost", 9, 1'b1);
    ram_write(9, 'h7777);
    ram_read("first_write_post_rst", 9, 1'b1);

    for (int i = 0; i < 16; i++) begin
      pc = i[3:0];
      #1;
      chk($sformatf("rom%0d", i), int'(instr), rom_exp[i]);
    end

    @(negedge clk);
    ram_addr = 4'd7;
    ram_oe = 1'b1;
    ram_we = 1'b1;
    ram_wdata = 16'h00AA;
    #1;
    chk("wr_rd_before", int'(ram_rdata), 0);
    tick();
    chk("wr_rd_after", int'(ram_rdata), 'h00AA);
    ram_we = 1'b0;
    model_mem[7] = 'h00AA;

    for (int i = 0; i < 100; i++) begin
      addr = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        data = int'($urandom_range(0, 65535));
        ram_write(addr, data);
      end else begin
        ram_read($sformatf("ram_rnd%0d", i), addr,
                 $urandom_range(0, 3) != 0);
      end
    end
    ram_oe = 1'b1;

    run_fib();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
